alu_exec_unit: RTL and testbench

- Execution end of the reservation-station issue interface.
- Accepts one shot per cycle (operands, ROB id, work type) and computes the result.
- Broadcasts the result on the ALU common data bus (alu_ready / alu_rob_id / alu_value), which the reservation station, LSB and ROB snoop.
- Single-cycle ops: fixed 1-cycle latency. Optional RV32M divide: iterative, with back-pressure via alu_busy.

---
 rtl/alu_exec_unit.sv | 206 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution end of the reservation-station issue interface.
// Single-cycle integer/branch ops broadcast on the ALU CDB one cycle after
// issue. Define ALU_MULDIV_EN to add RV32M: 1-cycle multiply and a 32-step
// restoring divider that back-pressures issue through alu_busy.
module alu_exec_unit #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              rs_shot,
  input  logic [31:0]       r1,
  input  logic [31:0]       r2,
  input  logic [ROB_W-1:0]  rob_id,
  input  logic [TYPE_W-1:0] work_type,
  output logic              alu_busy,
  output logic              alu_ready,
  output logic [ROB_W-1:0]  alu_rob_id,
  output logic [31:0]       alu_value
);

  typedef enum logic [TYPE_W-1:0] {
    OP_ADD    = TYPE_W'(0),  OP_SUB    = TYPE_W'(1),
    OP_SLL    = TYPE_W'(2),  OP_SLT    = TYPE_W'(3),
    OP_SLTU   = TYPE_W'(4),  OP_XOR    = TYPE_W'(5),
    OP_SRL    = TYPE_W'(6),  OP_SRA    = TYPE_W'(7),
    OP_OR     = TYPE_W'(8),  OP_AND    = TYPE_W'(9),
    OP_BEQ    = TYPE_W'(10), OP_BNE    = TYPE_W'(11),
    OP_BLT    = TYPE_W'(12), OP_BGE    = TYPE_W'(13),
    OP_BLTU   = TYPE_W'(14), OP_BGEU   = TYPE_W'(15),
    OP_MUL    = TYPE_W'(16), OP_MULH   = TYPE_W'(17),
    OP_MULHSU = TYPE_W'(18), OP_MULHU  = TYPE_W'(19),
    OP_DIV    = TYPE_W'(20), OP_DIVU   = TYPE_W'(21),
    OP_REM    = TYPE_W'(22), OP_REMU   = TYPE_W'(23)
  } op_e;

  op_e         op;
  logic [4:0]  shamt;
  logic        eq, lt_s, lt_u;
  logic [31:0] sc_value;
  logic        accept;
  logic        start_div;
  logic        div_last;
  logic [31:0] div_result;
  logic [ROB_W-1:0] div_rob;

  assign op     = op_e'(work_type);
  assign shamt  = r2[4:0];
  assign eq     = (r1 == r2);
  assign lt_s   = ($signed(r1) < $signed(r2));
  assign lt_u   = (r1 < r2);
  assign accept = rs_shot && rdy && !alu_busy && !flush;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e      state, state_nx;
  logic [63:0] mul_a, mul_b, prod;
  logic        r2_zero, div_ovf, is_div, div_signed, div_special;
  logic [31:0] div_q, div_r, div_d;
  logic [4:0]  div_cnt;
  logic        div_is_rem, div_neg;
  logic [32:0] r_shift, r_diff;
  logic        q_bit;
  logic [31:0] q_nx, r_nx;

  // One 64x64 product serves all four multiplies; only the extension differs.
  assign mul_a = {((op == OP_MULH) || (op == OP_MULHSU)) ? {32{r1[31]}} : 32'd0, r1};
  assign mul_b = {(op == OP_MULH) ? {32{r2[31]}} : 32'd0, r2};
  assign prod  = mul_a * mul_b;

  assign r2_zero     = (r2 == '0);
  assign div_ovf     = (r1 == 32'h8000_0000) && (r2 == '1);
  assign is_div      = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign div_signed  = (op == OP_DIV) || (op == OP_REM);
  assign div_special = r2_zero || (div_signed && div_ovf);
  assign start_div   = accept && is_div && !div_special;

  assign alu_busy = (state == S_DIV);
  assign div_last = (state == S_DIV) && (div_cnt == 5'd31) && !flush;

  // Restoring step; the final step feeds the CDB directly so the result
  // lands one edge after the 32nd busy cycle.
  assign r_shift = {div_r, div_q[31]};
  assign r_diff  = r_shift - {1'b0, div_d};
  assign q_bit   = !r_diff[32];
  assign r_nx    = q_bit ? r_diff[31:0] : r_shift[31:0];
  assign q_nx    = {div_q[30:0], q_bit};

  // Sign fix-up of the final quotient or remainder
  always_comb begin
    div_result = div_is_rem ? r_nx : q_nx;
    if (div_neg) div_result = ~div_result + 32'd1;
  end

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S_IDLE;
    else if (rdy) state <= state_nx;
  end

  // Divider next-state: IDLE and DONE both accept issue
  always_comb begin
    state_nx = state;
    case (state)
      S_DIV: begin
        if (flush)                  state_nx = S_IDLE;
        else if (div_cnt == 5'd31)  state_nx = S_DONE;
      end
      default: state_nx = start_div ? S_DIV : S_IDLE;
    endcase
  end

  // Divider datapath: load magnitudes on start, then shift one bit per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      div_r      <= '0;
      div_d      <= '0;
      div_cnt    <= '0;
      div_is_rem <= 1'b0;
      div_neg    <= 1'b0;
      div_rob    <= '0;
    end else if (rdy) begin
      if (start_div) begin
        div_q      <= (div_signed && r1[31]) ? (~r1 + 32'd1) : r1;
        div_d      <= (div_signed && r2[31]) ? (~r2 + 32'd1) : r2;
        div_r      <= '0;
        div_cnt    <= '0;
        div_is_rem <= (op == OP_REM) || (op == OP_REMU);
        div_neg    <= (op == OP_DIV) ? (r1[31] ^ r2[31]) :
                      (op == OP_REM) ? r1[31] : 1'b0;
        div_rob    <= rob_id;
      end else if (state == S_DIV) begin
        div_q   <= q_nx;
        div_r   <= r_nx;
        div_cnt <= div_cnt + 5'd1;
      end
    end
  end
`else
  assign alu_busy   = 1'b0;
  assign start_div  = 1'b0;
  assign div_last   = 1'b0;
  assign div_result = '0;
  assign div_rob    = '0;
`endif

  // Single-cycle result, including the divide cases resolved without iterating
  always_comb begin
    sc_value = '0;
    case (op)
      OP_ADD:    sc_value = r1 + r2;
      OP_SUB:    sc_value = r1 - r2;
      OP_SLL:    sc_value = r1 << shamt;
      OP_SLT:    sc_value = {31'd0, lt_s};
      OP_SLTU:   sc_value = {31'd0, lt_u};
      OP_XOR:    sc_value = r1 ^ r2;
      OP_SRL:    sc_value = r1 >> shamt;
      OP_SRA:    sc_value = $unsigned($signed(r1) >>> shamt);
      OP_OR:     sc_value = r1 | r2;
      OP_AND:    sc_value = r1 & r2;
      OP_BEQ:    sc_value = {31'd0, eq};
      OP_BNE:    sc_value = {31'd0, !eq};
      OP_BLT:    sc_value = {31'd0, lt_s};
      OP_BGE:    sc_value = {31'd0, !lt_s};
      OP_BLTU:   sc_value = {31'd0, lt_u};
      OP_BGEU:   sc_value = {31'd0, !lt_u};
`ifdef ALU_MULDIV_EN
      OP_MUL:    sc_value = prod[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  sc_value = prod[63:32];
      OP_DIV:    sc_value = r2_zero ? '1 : 32'h8000_0000;
      OP_DIVU:   sc_value = '1;
      OP_REM:    sc_value = r2_zero ? r1 : '0;
      OP_REMU:   sc_value = r1;
`endif
      default:   sc_value = '0;
    endcase
  end

  // CDB broadcast register: one-cycle pulse, value/tag hold between pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ready  <= 1'b0;
      alu_rob_id <= '0;
      alu_value  <= '0;
    end else if (rdy) begin
      if (accept && !start_div) begin
        alu_ready  <= 1'b1;
        alu_rob_id <= rob_id;
        alu_value  <= sc_value;
      end else if (div_last) begin
        alu_ready  <= 1'b1;
        alu_rob_id <= div_rob;
        alu_value  <= div_result;
      end else begin
        alu_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus multi-cycle sequences for
// alu_exec_unit. Expectations follow ALU_MULDIV_EN when it is defined.
module tb_alu_exec_unit;
  localparam int ROB_W  = 4;
  localparam int TYPE_W = 5;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, rdy, flush, rs_shot;
  logic [31:0]       r1, r2;
  logic [ROB_W-1:0]  rob_id;
  logic [TYPE_W-1:0] work_type;
  logic              alu_busy, alu_ready;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [31:0]       alu_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.ROB_W(ROB_W), .TYPE_W(TYPE_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rs_shot(rs_shot),
    .r1(r1), .r2(r2), .rob_id(rob_id), .work_type(work_type),
    .alu_busy(alu_busy), .alu_ready(alu_ready),
    .alu_rob_id(alu_rob_id), .alu_value(alu_value)
  );

  // Issuing into a busy unit is a protocol violation by the bench itself
  always @(posedge clk) begin
    if (rst && rdy && rs_shot && alu_busy) begin
      errors++;
      $display("FAIL protocol: shot issued while alu_busy=1 at %0t", $time);
    end
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] id);
    rs_shot = 1'b1; work_type = op; r1 = a; r2 = b; rob_id = id;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_chk(input string nm, input logic [3:0] id, input logic [31:0] v);
    chk({nm, " ready"}, {31'd0, alu_ready}, 32'd1);
    chk({nm, " tag"}, {28'd0, alu_rob_id}, {28'd0, id});
    chk({nm, " value"}, alu_value, v);
  endtask

  // Divide run: latency measured from the accepting edge, busy cycles counted
  task automatic div_run(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] id, input logic [31:0] exp);
    int lat;
    int busy_cnt;
    drive(op, a, b, id);
    step;
    rs_shot = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!alu_ready && lat < 100) begin
      if (alu_busy) busy_cnt++;
      step;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd33);
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'd32);
    chk({nm, " busy at done"}, {31'd0, alu_busy}, 32'd0);
    pulse_chk(nm, id, exp);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; rs_shot = 1'b0;
    r1 = '0; r2 = '0; rob_id = '0; work_type = '0;

    add(5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    add(5'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    add(5'd14, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    add(5'd0,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C);
    add(5'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    add(5'd2,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    add(5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    add(5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    add(5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    add(5'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    add(5'd8,  32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0);
    add(5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    add(5'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001);
    add(5'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    add(5'd12, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001);
    add(5'd13, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000);
    add(5'd15, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    add(5'd24, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000);
    add(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    add(5'd16, 32'h0000_0007, 32'h0000_0006, MD ? 32'h0000_002A : 32'h0);
    add(5'd17, 32'h8000_0000, 32'h8000_0000, MD ? 32'h4000_0000 : 32'h0);
    add(5'd18, 32'hFFFF_FFFF, 32'h0000_0002, MD ? 32'hFFFF_FFFF : 32'h0);
    add(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'hFFFF_FFFE : 32'h0);
    add(5'd21, 32'h0000_000A, 32'h0000_0000, MD ? 32'hFFFF_FFFF : 32'h0);
    add(5'd20, 32'h0000_0005, 32'h0000_0000, MD ? 32'hFFFF_FFFF : 32'h0);
    add(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'h0);
    add(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    add(5'd22, 32'h0000_0009, 32'h0000_0000, MD ? 32'h0000_0009 : 32'h0);
    add(5'd23, 32'h0000_000D, 32'h0000_0000, MD ? 32'h0000_000D : 32'h0);

    // Reset state
    #12;
    chk("reset ready", {31'd0, alu_ready}, 32'd0);
    chk("reset tag", {28'd0, alu_rob_id}, 32'd0);
    chk("reset value", alu_value, 32'd0);
    chk("reset busy", {31'd0, alu_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step;

    // First transaction and pulse width
    drive(5'd0, 32'd5, 32'd7, 4'd3);
    step;
    rs_shot = 1'b0;
    pulse_chk("add first", 4'd3, 32'd12);
    step;
    chk("add pulse end", {31'd0, alu_ready}, 32'd0);

    // Asynchronous reset mid-cycle clears a live pulse immediately
    drive(5'd0, 32'd100, 32'd1, 4'd5);
    step;
    rs_shot = 1'b0;
    pulse_chk("pre-reset", 4'd5, 32'd101);
    #2 rst = 1'b0;
    #1;
    chk("async reset ready", {31'd0, alu_ready}, 32'd0);
    chk("async reset tag", {28'd0, alu_rob_id}, 32'd0);
    chk("async reset value", alu_value, 32'd0);
    #1 rst = 1'b1;
    step;

    // Table: every vector issued back-to-back, one pulse per cycle
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      step;
      pulse_chk($sformatf("vec%0d op%0d", i, vecs[i].op), 4'(i), vecs[i].exp);
    end
    rs_shot = 1'b0;
    step;
    chk("table drain", {31'd0, alu_ready}, 32'd0);

    // rdy low freezes outputs and blocks issue
    drive(5'd0, 32'd3, 32'd4, 4'd1);
    step;
    pulse_chk("rdy pre", 4'd1, 32'd7);
    rdy = 1'b0;
    drive(5'd0, 32'd1, 32'd1, 4'd2);
    for (int k = 0; k < 3; k++) begin
      step;
      pulse_chk($sformatf("rdy hold%0d", k), 4'd1, 32'd7);
    end
    rdy = 1'b1;
    step;
    rs_shot = 1'b0;
    pulse_chk("rdy release", 4'd2, 32'd2);
    step;
    chk("rdy single pulse", {31'd0, alu_ready}, 32'd0);

    // Shot coinciding with flush is discarded
    drive(5'd0, 32'd9, 32'd9, 4'd4);
    flush = 1'b1;
    step;
    flush = 1'b0;
    rs_shot = 1'b0;
    chk("flush drop", {31'd0, alu_ready}, 32'd0);
    chk("flush busy", {31'd0, alu_busy}, 32'd0);

    if (MD) begin
      div_run("div -100/7", 5'd20, 32'hFFFF_FF9C, 32'd7, 4'd9, 32'hFFFF_FFF2);
      // Issue in the DONE cycle is accepted
      drive(5'd0, 32'd2, 32'd3, 4'd6);
      step;
      rs_shot = 1'b0;
      pulse_chk("done issue", 4'd6, 32'd5);
      div_run("rem -100/7", 5'd22, 32'hFFFF_FF9C, 32'd7, 4'd10, 32'hFFFF_FFFE);
      div_run("divu 100/7", 5'd21, 32'd100, 32'd7, 4'd11, 32'd14);
      div_run("remu 100/7", 5'd23, 32'd100, 32'd7, 4'd12, 32'd2);
      div_run("div 7/-2", 5'd20, 32'd7, 32'hFFFF_FFFE, 4'd13, 32'hFFFF_FFFD);

      // Flush aborts an in-flight divide
      begin
        int pulses;
        drive(5'd21, 32'd1000, 32'd3, 4'd7);
        step;
        rs_shot = 1'b0;
        chk("divu busy", {31'd0, alu_busy}, 32'd1);
        repeat (9) step;
        flush = 1'b1;
        step;
        flush = 1'b0;
        chk("abort busy", {31'd0, alu_busy}, 32'd0);
        chk("abort ready", {31'd0, alu_ready}, 32'd0);
        pulses = 0;
        repeat (40) begin
          step;
          if (alu_ready) pulses++;
        end
        chk("abort no pulse", 32'(pulses), 32'd0);
      end
    end

    drive(5'd0, 32'd2, 32'd2, 4'd8);
    step;
    rs_shot = 1'b0;
    pulse_chk("post flush add", 4'd8, 32'd4);
    step;
    chk("post flush end", {31'd0, alu_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
